// File: rtl/tx_frame_sequencer.sv
// BPSK TX frame scheduler: pulls 32-bit AXIS payload words and emits PREAMBLE -> SYNC -> PAYLOAD
// -> GUARD, one symbol bit per SPS dac_dco_clk cycles, with carrier enable and status pulses.
module tx_frame_sequencer #(
    parameter int unsigned SPS           = 16,
    parameter int unsigned PREAMBLE_BITS = 32,
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int unsigned SYNC_BITS     = 32,
    parameter int unsigned GUARD_SYMBOLS = 8
) (
    input  logic        dac_dco_clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        mod_en,
    output logic        mod_bit,
    output logic        sym_strobe,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int unsigned MaxSymA = (PREAMBLE_BITS > GUARD_SYMBOLS) ? PREAMBLE_BITS
                                                                      : GUARD_SYMBOLS;
    localparam int unsigned MaxSym  = (MaxSymA > 32) ? MaxSymA : 32;
    localparam int unsigned SymW    = $clog2(MaxSym);
    localparam int unsigned SmpW    = (SPS > 1) ? $clog2(SPS) : 1;

    localparam logic [SmpW-1:0] SmpLast   = SmpW'(SPS - 1);
    localparam logic [SymW-1:0] PreLast   = SymW'(PREAMBLE_BITS - 1);
    localparam logic [SymW-1:0] SyncLast  = SymW'(SYNC_BITS - 1);
    localparam logic [SymW-1:0] WordLast  = SymW'(31);
    localparam logic [SymW-1:0] GuardLast = SymW'(GUARD_SYMBOLS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSync,
        StPayload,
        StGuard
    } state_e;

    state_e          state_q, state_d;
    logic [SmpW-1:0] smp_q, smp_d;
    logic [SymW-1:0] sym_q, sym_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     shreg_q, shreg_d;
    logic            buf_vld_q, buf_vld_d;
    logic            buf_last_q, buf_last_d;
    logic            cur_last_q, cur_last_d;
    logic            last_flag_q, last_flag_d;
    logic            tready_q, tready_d;
    logic            mod_en_q, mod_en_d;
    logic            mod_bit_q, mod_bit_d;
    logic            sym_strobe_q, sym_strobe_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q, underrun_d;
    logic            sym_end;
    logic            hs;
    logic            word_start;

    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;

    always_comb begin
        state_d      = state_q;
        smp_d        = smp_q;
        sym_d        = sym_q;
        buf_d        = buf_q;
        shreg_d      = shreg_q;
        buf_vld_d    = buf_vld_q;
        buf_last_d   = buf_last_q;
        cur_last_d   = cur_last_q;
        last_flag_d  = last_flag_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        word_start   = 1'b0;
        sym_end      = (smp_q == SmpLast);
        hs           = tready_q & s_axis_tvalid;

        if (state_q != StIdle) begin
            smp_d = sym_end ? '0 : smp_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                // A word left in the buffer by an underrun also starts the next frame.
                if (s_axis_tvalid || buf_vld_q) begin
                    state_d     = StPreamble;
                    smp_d       = '0;
                    sym_d       = '0;
                    last_flag_d = buf_vld_q & buf_last_q;
                end
            end
            StPreamble: begin
                if (sym_end) begin
                    if (sym_q == PreLast) begin
                        state_d = StSync;
                        sym_d   = '0;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StSync: begin
                if (sym_end) begin
                    if (sym_q == SyncLast) begin
                        word_start = 1'b1;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StPayload: begin
                if (sym_end) begin
                    shreg_d = {shreg_q[30:0], 1'b0};
                    if (sym_q == WordLast) begin
                        if (cur_last_q) begin
                            state_d     = StGuard;
                            sym_d       = '0;
                            last_flag_d = 1'b0;
                        end else begin
                            word_start = 1'b1;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StGuard: begin
                if (sym_end) begin
                    if (sym_q == GuardLast) begin
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Payload word boundary: load shifter from the buffer or abort the frame.
        if (word_start) begin
            sym_d = '0;
            if (buf_vld_q) begin
                state_d    = StPayload;
                shreg_d    = buf_q;
                cur_last_d = buf_last_q;
                buf_vld_d  = 1'b0;
            end else begin
                state_d     = StGuard;
                underrun_d  = 1'b1;
                last_flag_d = 1'b0;
            end
        end

        if (hs) begin
            buf_d       = s_axis_tdata;
            buf_last_d  = s_axis_tlast;
            buf_vld_d   = 1'b1;
            last_flag_d = last_flag_d | s_axis_tlast;
        end

        mod_en_d     = state_d inside {StPreamble, StSync, StPayload};
        busy_d       = (state_d != StIdle);
        sym_strobe_d = mod_en_d && (smp_d == '0);
        tready_d     = mod_en_d && !buf_vld_d && !last_flag_d;

        case (state_d)
            StPreamble: mod_bit_d = ~sym_d[0];
            StSync:     mod_bit_d = SYNC_WORD[~sym_d[4:0]];
            StPayload:  mod_bit_d = shreg_d[31];
            default:    mod_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge dac_dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            smp_q        <= '0;
            sym_q        <= '0;
            buf_q        <= '0;
            shreg_q      <= '0;
            buf_vld_q    <= 1'b0;
            buf_last_q   <= 1'b0;
            cur_last_q   <= 1'b0;
            last_flag_q  <= 1'b0;
            tready_q     <= 1'b0;
            mod_en_q     <= 1'b0;
            mod_bit_q    <= 1'b0;
            sym_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            sym_q        <= sym_d;
            buf_q        <= buf_d;
            shreg_q      <= shreg_d;
            buf_vld_q    <= buf_vld_d;
            buf_last_q   <= buf_last_d;
            cur_last_q   <= cur_last_d;
            last_flag_q  <= last_flag_d;
            tready_q     <= tready_d;
            mod_en_q     <= mod_en_d;
            mod_bit_q    <= mod_bit_d;
            sym_strobe_q <= sym_strobe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign mod_en        = mod_en_q;
    assign mod_bit       = mod_bit_q;
    assign sym_strobe    = sym_strobe_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: expected symbol bits are queued as frames are offered
// and popped on every sym_strobe; frame timing and handshake counts are checked per scenario.
module tb_tx_frame_sequencer;

    localparam int SPS_A   = 4;
    localparam int PRE_A   = 8;
    localparam int SYNC_A  = 32;
    localparam int GUARD_A = 2;
    localparam int SPS_B   = 2;
    localparam int PRE_B   = 8;
    localparam int SYNC_B  = 16;
    localparam int GUARD_B = 2;
    localparam logic [31:0] SYNC_WORD = 32'h1ACFFC1D;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] tdata_a  = '0;
    logic        tlast_a  = 1'b0;
    logic        tvalid_a = 1'b0;
    logic        tready_a, mod_en_a, mod_bit_a, strobe_a, busy_a, fd_a, ur_a;
    logic [31:0] tdata_b  = '0;
    logic        tlast_b  = 1'b0;
    logic        tvalid_b = 1'b0;
    logic        tready_b, mod_en_b, mod_bit_b, strobe_b, busy_b, fd_b, ur_b;

    tx_frame_sequencer #(
        .SPS(SPS_A), .PREAMBLE_BITS(PRE_A), .SYNC_WORD(SYNC_WORD), .SYNC_BITS(SYNC_A),
        .GUARD_SYMBOLS(GUARD_A)
    ) u_dut_a (
        .dac_dco_clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata_a), .s_axis_tkeep(4'hF),
        .s_axis_tlast(tlast_a), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
        .mod_en(mod_en_a), .mod_bit(mod_bit_a), .sym_strobe(strobe_a), .busy(busy_a),
        .frame_done(fd_a), .underrun(ur_a)
    );

    tx_frame_sequencer #(
        .SPS(SPS_B), .PREAMBLE_BITS(PRE_B), .SYNC_WORD(SYNC_WORD), .SYNC_BITS(SYNC_B),
        .GUARD_SYMBOLS(GUARD_B)
    ) u_dut_b (
        .dac_dco_clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata_b), .s_axis_tkeep(4'hF),
        .s_axis_tlast(tlast_b), .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b),
        .mod_en(mod_en_b), .mod_bit(mod_bit_b), .sym_strobe(strobe_b), .busy(busy_b),
        .frame_done(fd_b), .underrun(ur_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboards of expected symbol bits, and the AXIS source queue for DUT A.
    bit          exp_a[$];
    bit          exp_b[$];
    logic [32:0] src_a[$];
    bit          hs_now_a;

    task automatic push_hdr_a();
        logic [31:0] sw = SYNC_WORD;
        for (int i = 0; i < PRE_A; i++) exp_a.push_back(i % 2 == 0);
        for (int i = 0; i < SYNC_A; i++) exp_a.push_back(sw[31-i]);
    endtask

    task automatic push_word_a(input logic [31:0] w);
        for (int i = 0; i < 32; i++) exp_a.push_back(w[31-i]);
    endtask

    task automatic push_hdr_b();
        logic [31:0] sw = SYNC_WORD;
        for (int i = 0; i < PRE_B; i++) exp_b.push_back(i % 2 == 0);
        for (int i = 0; i < SYNC_B; i++) exp_b.push_back(sw[31-i]);
    endtask

    task automatic push_word_b(input logic [31:0] w);
        for (int i = 0; i < 32; i++) exp_b.push_back(w[31-i]);
    endtask

    always @(posedge clk) begin
        hs_now_a = tvalid_a && tready_a;
        #1;
        if (hs_now_a && src_a.size() != 0) void'(src_a.pop_front());
        if (src_a.size() != 0) begin
            tvalid_a = 1'b1;
            {tlast_a, tdata_a} = src_a[0];
        end else begin
            tvalid_a = 1'b0;
            tlast_a  = 1'b0;
            tdata_a  = '0;
        end
    end

    int since_a, en_run_a, low_run_a, en_len_a, low_len_a, fd_gap_a;
    int fd_cnt_a, ur_cnt_a, hs_cnt_a, ur_low_a;
    bit run_a, prev_bit_a, ur_en_a;
    int en_run_b, en_len_b, fd_cnt_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_run_a  = 0;
            low_run_a = 0;
            run_a     = 1'b0;
        end else begin
            if (tvalid_a && tready_a) hs_cnt_a++;
            if (strobe_a) begin
                chk_bit("a_sb_nonempty", exp_a.size() != 0, 1'b1);
                if (exp_a.size() != 0) chk_bit("a_sym_bit", mod_bit_a, exp_a.pop_front());
                if (run_a) chk_int("a_strobe_period", since_a, SPS_A);
                since_a = 1;
            end else if (mod_en_a) begin
                since_a++;
                chk_bit("a_bit_hold", mod_bit_a, prev_bit_a);
            end
            if (!mod_en_a) begin
                chk_bit("a_tready_off", tready_a, 1'b0);
                chk_bit("a_bit_off", mod_bit_a, 1'b0);
                chk_bit("a_strobe_off", strobe_a, 1'b0);
            end
            run_a = mod_en_a;
            if (mod_en_a) begin
                if (low_run_a != 0) low_len_a = low_run_a;
                en_run_a++;
                low_run_a = 0;
            end else begin
                if (en_run_a != 0) en_len_a = en_run_a;
                en_run_a = 0;
                low_run_a++;
            end
            if (fd_a) begin
                fd_cnt_a++;
                fd_gap_a = low_run_a - 1;
            end
            if (ur_a) begin
                ur_cnt_a++;
                ur_en_a  = mod_en_a;
                ur_low_a = low_run_a;
            end
            prev_bit_a = mod_bit_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            en_run_b = 0;
        end else begin
            if (strobe_b) begin
                chk_bit("b_sb_nonempty", exp_b.size() != 0, 1'b1);
                if (exp_b.size() != 0) chk_bit("b_sym_bit", mod_bit_b, exp_b.pop_front());
            end
            if (!mod_en_b) chk_bit("b_strobe_off", strobe_b, 1'b0);
            if (mod_en_b) begin
                en_run_b++;
            end else begin
                if (en_run_b != 0) en_len_b = en_run_b;
                en_run_b = 0;
            end
            if (fd_b) fd_cnt_b++;
        end
    end

    task automatic wait_fd_a(input int target, input int budget);
        int n = 0;
        while (fd_cnt_a < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_bit("a_frame_done_timeout", fd_cnt_a >= target, 1'b1);
    endtask

    task automatic wait_ur_a(input int target, input int budget);
        int n = 0;
        while (ur_cnt_a < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_bit("a_underrun_timeout", ur_cnt_a >= target, 1'b1);
    endtask

    task automatic wait_fd_b(input int target, input int budget);
        int n = 0;
        while (fd_cnt_b < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_bit("b_frame_done_timeout", fd_cnt_b >= target, 1'b1);
    endtask

    task automatic chk_idle_outputs_a(input string tag);
        chk_bit({tag, "_tready"}, tready_a, 1'b0);
        chk_bit({tag, "_mod_en"}, mod_en_a, 1'b0);
        chk_bit({tag, "_mod_bit"}, mod_bit_a, 1'b0);
        chk_bit({tag, "_strobe"}, strobe_a, 1'b0);
        chk_bit({tag, "_busy"}, busy_a, 1'b0);
        chk_bit({tag, "_frame_done"}, fd_a, 1'b0);
        chk_bit({tag, "_underrun"}, ur_a, 1'b0);
    endtask

    initial begin
        int  hs0, fd0, ur0, n;
        bit  got;

        // Reset values
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs_a("rst_a");
        chk_bit("rst_b_tready", tready_b, 1'b0);
        chk_bit("rst_b_mod_en", mod_en_b, 1'b0);
        chk_bit("rst_b_busy", busy_b, 1'b0);
        chk_bit("rst_b_frame_done", fd_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-word frame
        hs0 = hs_cnt_a;
        push_hdr_a();
        push_word_a(32'hA5A5A5A5);
        src_a.push_back({1'b1, 32'hA5A5A5A5});
        wait_fd_a(1, 2000);
        repeat (3) @(negedge clk);
        chk_int("t1_mod_en_len", en_len_a, (PRE_A + SYNC_A + 32) * SPS_A);
        chk_int("t1_frame_done_gap", fd_gap_a, GUARD_A * SPS_A);
        chk_int("t1_frame_done_once", fd_cnt_a, 1);
        chk_int("t1_handshakes", hs_cnt_a - hs0, 1);
        chk_int("t1_sb_drained", exp_a.size(), 0);
        chk_int("t1_no_underrun", ur_cnt_a, 0);
        chk_bit("t1_idle_busy", busy_a, 1'b0);

        // Three-word frame with tvalid held high
        hs0 = hs_cnt_a;
        push_hdr_a();
        push_word_a(32'h01234567);
        push_word_a(32'h89ABCDEF);
        push_word_a(32'hF00DCAFE);
        src_a.push_back({1'b0, 32'h01234567});
        src_a.push_back({1'b0, 32'h89ABCDEF});
        src_a.push_back({1'b1, 32'hF00DCAFE});
        wait_fd_a(2, 4000);
        chk_int("t2_mod_en_len", en_len_a, (PRE_A + SYNC_A + 96) * SPS_A);
        chk_int("t2_handshakes", hs_cnt_a - hs0, 3);
        chk_int("t2_sb_drained", exp_a.size(), 0);

        // Second word withheld: underrun, then late word forms its own frame
        hs0 = hs_cnt_a;
        push_hdr_a();
        push_word_a(32'hDEADBEEF);
        src_a.push_back({1'b0, 32'hDEADBEEF});
        wait_ur_a(1, 2000);
        wait_fd_a(3, 2000);
        chk_bit("t3_underrun_mod_en", ur_en_a, 1'b0);
        chk_int("t3_underrun_first_low", ur_low_a, 1);
        chk_int("t3_mod_en_len", en_len_a, (PRE_A + SYNC_A + 32) * SPS_A);
        chk_int("t3_underrun_once", ur_cnt_a, 1);
        chk_int("t3_sb_drained", exp_a.size(), 0);
        chk_int("t3_handshakes", hs_cnt_a - hs0, 1);
        push_hdr_a();
        push_word_a(32'h5A5AC3C3);
        src_a.push_back({1'b1, 32'h5A5AC3C3});
        wait_fd_a(4, 2000);
        chk_int("t3_late_mod_en_len", en_len_a, (PRE_A + SYNC_A + 32) * SPS_A);
        chk_int("t3_late_sb_drained", exp_a.size(), 0);
        chk_int("t3_late_handshakes", hs_cnt_a - hs0, 2);
        chk_int("t3_late_no_underrun", ur_cnt_a, 1);

        // Back-to-back frames
        push_hdr_a();
        push_word_a(32'h13579BDF);
        push_hdr_a();
        push_word_a(32'h2468ACE0);
        src_a.push_back({1'b1, 32'h13579BDF});
        src_a.push_back({1'b1, 32'h2468ACE0});
        wait_fd_a(6, 4000);
        chk_int("t4_gap_len", low_len_a, GUARD_A * SPS_A + 1);
        chk_int("t4_mod_en_len", en_len_a, (PRE_A + SYNC_A + 32) * SPS_A);
        chk_int("t4_sb_drained", exp_a.size(), 0);

        // Asynchronous reset in the middle of the payload
        push_hdr_a();
        push_word_a(32'hCAFEF00D);
        src_a.push_back({1'b1, 32'hCAFEF00D});
        repeat (200) @(negedge clk);
        chk_bit("t5_in_frame", mod_en_a, 1'b1);
        fd0 = fd_cnt_a;
        ur0 = ur_cnt_a;
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs_a("t5_async");
        exp_a.delete();
        src_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_int("t5_no_frame_done", fd_cnt_a, fd0);
        chk_int("t5_no_underrun", ur_cnt_a, ur0);
        chk_bit("t5_idle", busy_a, 1'b0);
        push_hdr_a();
        push_word_a(32'h0F0F1234);
        src_a.push_back({1'b1, 32'h0F0F1234});
        wait_fd_a(fd0 + 1, 2000);
        chk_int("t5_mod_en_len", en_len_a, (PRE_A + SYNC_A + 32) * SPS_A);
        chk_int("t5_sb_drained", exp_a.size(), 0);

        // SPS=2 with a 16-bit sync word
        push_hdr_b();
        push_word_b(32'h3C5A0F96);
        @(posedge clk);
        #1;
        tvalid_b = 1'b1;
        tdata_b  = 32'h3C5A0F96;
        tlast_b  = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (tready_b) got = 1'b1;
        end
        chk_bit("t6_handshake", got, 1'b1);
        @(posedge clk);
        #1;
        tvalid_b = 1'b0;
        tlast_b  = 1'b0;
        wait_fd_b(1, 1000);
        chk_int("t6_mod_en_len", en_len_b, (PRE_B + SYNC_B + 32) * SPS_B);
        chk_int("t6_sb_drained", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
